// File: rtl/xbus_pkg.sv
// xbus master shared types: top/beat phases and width helpers.
// Byte-serial 4-phase pad bus behind the load/store unit.
package xbus_pkg;

  typedef enum logic [2:0] {
    T_IDLE,
    T_ADDR,
    T_WAIT_WD,
    T_DATA,
    T_RD_HOLD,
    T_FIN
  } top_e;

  typedef enum logic {
    B_WAIT_LOW,
    B_WAIT_HIGH
  } beat_e;

  localparam logic [7:0] OE_DRIVE = 8'hFF;
  localparam logic [7:0] OE_FLOAT = 8'h00;

  function automatic int lane_w(input int n);
    return 8 * n;
  endfunction

  function automatic int tmo_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/xbus_sync.sv
// Multi-flop synchroniser for the asynchronous host ack.
// Chain resets to 0 so a stuck-high ack is seen only after STAGES edges.
module xbus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/xbus_master.sv
// Byte-serial external bus master: address phase, then bursts of
// multi-byte words as 4-phase req/ack beats, with flow control and timeout.
module xbus_master
  import xbus_pkg::*;
#(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 1,
  parameter int LEN_W          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [8*ADDR_BYTES-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]          cmd_len,
  input  logic                      wd_valid,
  output logic                      wd_ready,
  input  logic [8*DATA_BYTES-1:0]   wd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [8*DATA_BYTES-1:0]   rd_data,
  output logic                      done,
  output logic                      err,
  output logic                      busy,
  output logic                      bus_req,
  input  logic                      bus_ack,
  output logic                      bus_rd,
  output logic                      bus_wr,
  output logic [7:0]                bus_dout,
  output logic [7:0]                bus_oe,
  input  logic [7:0]                bus_din
);

  localparam int AW = lane_w(ADDR_BYTES);
  localparam int DW = lane_w(DATA_BYTES);
  localparam int TW = tmo_w(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [1:0] A_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] D_LAST = 2'(DATA_BYTES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic ack_s;

  xbus_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus_ack),
    .q    (ack_s)
  );

  top_e            state_q, state_d;
  beat_e           beat_q, beat_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            write_q, write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            wd_ready_q, wd_ready_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_rd_q, bus_rd_d;
  logic            bus_wr_q, bus_wr_d;
  logic [7:0]      bus_dout_q, bus_dout_d;
  logic [7:0]      bus_oe_q, bus_oe_d;

  logic       is_addr;
  logic       drive;
  logic       last;
  logic       waiting;
  logic       fin_go;
  logic       fin_err;
  logic [4:0] sh;
  logic [7:0] byte_out;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    bcnt_d      = bcnt_q;
    wcnt_d      = wcnt_q;
    len_d       = len_q;
    tcnt_d      = tcnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    wd_ready_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    bus_req_d   = bus_req_q;
    bus_rd_d    = bus_rd_q;
    bus_wr_d    = bus_wr_q;
    bus_dout_d  = bus_dout_q;
    bus_oe_d    = bus_oe_q;
    waiting     = 1'b0;
    fin_go      = 1'b0;
    fin_err     = 1'b0;
    last        = 1'b0;
    is_addr     = (state_q == T_ADDR);
    drive       = is_addr | write_q;
    sh          = {bcnt_q, 3'b000};
    byte_out    = is_addr ? 8'(addr_q >> sh) : 8'(wd_q >> sh);

    unique case (state_q)
      T_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d  = cmd_write;
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          wcnt_d   = '0;
          bcnt_d   = '0;
          tcnt_d   = '0;
          beat_d   = B_WAIT_LOW;
          bus_rd_d = ~cmd_write;
          bus_wr_d = cmd_write;
          state_d  = T_ADDR;
        end
      end
      T_ADDR, T_DATA: begin
        if (beat_q == B_WAIT_LOW) begin
          if (!ack_s) begin
            bus_req_d  = 1'b1;
            bus_dout_d = byte_out;
            bus_oe_d   = drive ? OE_DRIVE : OE_FLOAT;
            beat_d     = B_WAIT_HIGH;
            tcnt_d     = '0;
          end else begin
            waiting = 1'b1;
          end
        end else if (ack_s) begin
          bus_req_d = 1'b0;
          bus_oe_d  = OE_FLOAT;
          beat_d    = B_WAIT_LOW;
          tcnt_d    = '0;
          if (!drive) begin
            rd_data_d = (rd_data_q & ~(DW'(8'hFF) << sh))
                      | (DW'(bus_din) << sh);
          end
          last = is_addr ? (bcnt_q == A_LAST) : (bcnt_q == D_LAST);
          if (!last) begin
            bcnt_d = bcnt_q + 2'd1;
          end else begin
            bcnt_d = '0;
            if (is_addr) begin
              state_d = write_q ? T_WAIT_WD : T_DATA;
            end else if (!write_q) begin
              rd_valid_d = 1'b1;
              state_d    = T_RD_HOLD;
            end else if (wcnt_q == len_q) begin
              fin_go = 1'b1;
            end else begin
              wcnt_d  = wcnt_q + 1'b1;
              state_d = T_WAIT_WD;
            end
          end
        end else begin
          waiting = 1'b1;
        end
      end
      T_WAIT_WD: begin
        if (wd_valid) begin
          wd_d       = wd_data;
          wd_ready_d = 1'b1;
          bcnt_d     = '0;
          tcnt_d     = '0;
          beat_d     = B_WAIT_LOW;
          state_d    = T_DATA;
        end
      end
      T_RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (wcnt_q == len_q) begin
            fin_go = 1'b1;
          end else begin
            wcnt_d  = wcnt_q + 1'b1;
            bcnt_d  = '0;
            tcnt_d  = '0;
            beat_d  = B_WAIT_LOW;
            state_d = T_DATA;
          end
        end
      end
      T_FIN: begin
        state_d = T_IDLE;
      end
      default: begin
        state_d = T_IDLE;
      end
    endcase

    // A stalled ack edge aborts the whole burst.
    if (waiting) begin
      tcnt_d = tcnt_q + 1'b1;
      if (TMO_EN && (tcnt_q == T_LAST)) begin
        bus_req_d  = 1'b0;
        bus_oe_d   = OE_FLOAT;
        rd_valid_d = 1'b0;
        fin_go     = 1'b1;
        fin_err    = 1'b1;
      end
    end

    if (fin_go) begin
      state_d  = T_FIN;
      bus_rd_d = 1'b0;
      bus_wr_d = 1'b0;
      done_d   = 1'b1;
      err_d    = fin_err;
    end

    cmd_ready_d = (state_d == T_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= T_IDLE;
      beat_q      <= B_WAIT_LOW;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      len_q       <= '0;
      tcnt_q      <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wd_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      bus_req_q   <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_dout_q  <= '0;
      bus_oe_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      bcnt_q      <= bcnt_d;
      wcnt_q      <= wcnt_d;
      len_q       <= len_d;
      tcnt_q      <= tcnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wd_ready_q  <= wd_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      bus_req_q   <= bus_req_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      bus_dout_q  <= bus_dout_d;
      bus_oe_q    <= bus_oe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = ~cmd_ready_q;
  assign wd_ready  = wd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_rd    = bus_rd_q;
  assign bus_wr    = bus_wr_q;
  assign bus_dout  = bus_dout_q;
  assign bus_oe    = bus_oe_q;

endmodule

// File: tb/tb_xbus_master.sv
// Directed bench for xbus_master: two instances (1-byte words without
// timeout, 2-byte words with a 16-cycle timeout) driven by host models.
module tb_xbus_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        a_cmd_valid = 0, a_cmd_write = 0;
  logic [15:0] a_cmd_addr = '0;
  logic [3:0]  a_cmd_len = '0;
  logic        a_wd_valid = 0, a_rd_ready = 0;
  logic [7:0]  a_wd_data = '0;
  logic        a_cmd_ready, a_wd_ready, a_rd_valid, a_done, a_err, a_busy;
  logic [7:0]  a_rd_data;
  logic        a_req, a_rd, a_wr;
  logic        a_ack = 1'b0;
  logic [7:0]  a_dout, a_oe;
  logic [7:0]  a_din = 8'h00;

  logic        b_cmd_valid = 0, b_cmd_write = 0;
  logic [15:0] b_cmd_addr = '0;
  logic [3:0]  b_cmd_len = '0;
  logic        b_wd_valid = 0, b_rd_ready = 0;
  logic [15:0] b_wd_data = '0;
  logic        b_cmd_ready, b_wd_ready, b_rd_valid, b_done, b_err, b_busy;
  logic [15:0] b_rd_data;
  logic        b_req, b_rd, b_wr;
  logic        b_ack = 1'b0;
  logic [7:0]  b_dout, b_oe;
  logic [7:0]  b_din = 8'h00;

  xbus_master #(
    .ADDR_BYTES(2), .DATA_BYTES(1), .LEN_W(4),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_write(a_cmd_write), .cmd_addr(a_cmd_addr), .cmd_len(a_cmd_len),
    .wd_valid(a_wd_valid), .wd_ready(a_wd_ready), .wd_data(a_wd_data),
    .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data),
    .done(a_done), .err(a_err), .busy(a_busy),
    .bus_req(a_req), .bus_ack(a_ack), .bus_rd(a_rd), .bus_wr(a_wr),
    .bus_dout(a_dout), .bus_oe(a_oe), .bus_din(a_din)
  );

  xbus_master #(
    .ADDR_BYTES(2), .DATA_BYTES(2), .LEN_W(4),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(b_cmd_write), .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len),
    .wd_valid(b_wd_valid), .wd_ready(b_wd_ready), .wd_data(b_wd_data),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
    .done(b_done), .err(b_err), .busy(b_busy),
    .bus_req(b_req), .bus_ack(b_ack), .bus_rd(b_rd), .bus_wr(b_wr),
    .bus_dout(b_dout), .bus_oe(b_oe), .bus_din(b_din)
  );

  // Host A: acks every beat, feeds read bytes from a_rq, logs {oe,dout}.
  logic        a_hold = 1'b0;
  logic        a_mute = 1'b0;
  logic [7:0]  a_rq[$];
  logic [15:0] a_log[$];

  always @(posedge clk) begin
    #1;
    if (a_hold) begin
      a_ack = 1'b1;
    end else if (a_req && !a_ack && !(a_mute && a_oe == 8'h00)) begin
      a_log.push_back(a_oe == 8'hFF ? {8'hFF, a_dout} : 16'h0000);
      if (a_oe == 8'h00) a_din = (a_rq.size() > 0) ? a_rq.pop_front() : 8'h00;
      a_ack = 1'b1;
    end else if (!a_req && a_ack) begin
      a_ack = 1'b0;
    end
  end

  logic        b_mute = 1'b0;
  logic [15:0] b_log[$];
  int          b_wdr_n = 0;
  int          b_done_n = 0;

  always @(posedge clk) begin
    #1;
    if (b_req && !b_ack && !b_mute) begin
      b_log.push_back(b_oe == 8'hFF ? {8'hFF, b_dout} : 16'h0000);
      b_ack = 1'b1;
    end else if (!b_req && b_ack) begin
      b_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (b_wd_ready) b_wdr_n++;
    if (b_done) b_done_n++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_issue(input logic wr, input logic [15:0] addr,
                         input logic [3:0] len);
    @(negedge clk);
    a_cmd_write = wr;
    a_cmd_addr  = addr;
    a_cmd_len   = len;
    a_cmd_valid = 1'b1;
    @(negedge clk);
    a_cmd_valid = 1'b0;
  endtask

  task automatic b_issue(input logic wr, input logic [15:0] addr,
                         input logic [3:0] len);
    @(negedge clk);
    b_cmd_write = wr;
    b_cmd_addr  = addr;
    b_cmd_len   = len;
    b_cmd_valid = 1'b1;
    @(negedge clk);
    b_cmd_valid = 1'b0;
  endtask

  task automatic a_wait_rd();
    int n = 0;
    while (!a_rd_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic a_take(input logic [7:0] exp, input string tag);
    a_wait_rd();
    chk({tag, "_valid"}, 32'(a_rd_valid), 32'd1);
    chk(tag, 32'(a_rd_data), 32'(exp));
    a_rd_ready = 1'b1;
    @(negedge clk);
    a_rd_ready = 1'b0;
  endtask

  task automatic a_chk_log(input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input string tag);
    logic [15:0] e[3];
    e = '{e0, e1, e2};
    chk({tag, "_beats"}, 32'(a_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_beat%0d", tag, i),
          32'(i < a_log.size() ? a_log[i] : 16'hDEAD), 32'(e[i]));
  endtask

  initial begin
    int n;
    logic flag;
    logic [15:0] exp_b[6];

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(a_cmd_ready), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_req", 32'(a_req), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_oe", 32'(a_oe), 32'd0);
    chk("rst_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("rst_b_cmd_ready", 32'(b_cmd_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single read
    a_log.delete();
    a_rq.push_back(8'hA5);
    a_issue(1'b0, 16'h1234, 4'd0);
    chk("t1_bus_rd", 32'(a_rd), 32'd1);
    chk("t1_cmd_ready", 32'(a_cmd_ready), 32'd0);
    a_take(8'hA5, "t1_rd_data");
    chk("t1_done", 32'(a_done), 32'd1);
    chk("t1_err", 32'(a_err), 32'd0);
    chk("t1_bus_rd_off", 32'(a_rd), 32'd0);
    a_chk_log(16'hFF34, 16'hFF12, 16'h0000, "t1");
    @(negedge clk);
    chk("t1_idle", 32'(a_cmd_ready), 32'd1);
    chk("t1_done_pulse", 32'(a_done), 32'd0);

    // 2: write burst of two 16-bit words
    b_log.delete();
    b_issue(1'b1, 16'h5678, 4'd1);
    chk("t2_bus_wr", 32'(b_wr), 32'd1);
    b_wd_data  = 16'hBEEF;
    b_wd_valid = 1'b1;
    n = 0;
    while (!b_wd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t2_wd_ready0", 32'(b_wd_ready), 32'd1);
    b_wd_data = 16'h0102;
    @(negedge clk);
    n = 0;
    while (!b_wd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t2_wd_ready1", 32'(b_wd_ready), 32'd1);
    b_wd_valid = 1'b0;
    n = 0;
    while (!b_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t2_done", 32'(b_done), 32'd1);
    chk("t2_err", 32'(b_err), 32'd0);
    chk("t2_bus_wr_off", 32'(b_wr), 32'd0);
    repeat (2) @(negedge clk);
    chk("t2_wd_pulses", 32'(b_wdr_n), 32'd2);
    chk("t2_done_pulses", 32'(b_done_n), 32'd1);
    chk("t2_idle", 32'(b_cmd_ready), 32'd1);
    exp_b = '{16'hFF78, 16'hFF56, 16'hFFEF, 16'hFFBE, 16'hFF02, 16'hFF01};
    chk("t2_beats", 32'(b_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_beat%0d", i),
          32'(i < b_log.size() ? b_log[i] : 16'hDEAD), 32'(exp_b[i]));

    // 3: read burst with consumer stall after word 0
    a_rq.delete();
    a_rq.push_back(8'h11);
    a_rq.push_back(8'h22);
    a_rq.push_back(8'h33);
    a_issue(1'b0, 16'h2000, 4'd2);
    a_wait_rd();
    chk("t3_w0", 32'(a_rd_data), 32'h11);
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (a_req) flag = 1'b1;
    end
    chk("t3_req_during_hold", 32'(flag), 32'd0);
    chk("t3_valid_held", 32'(a_rd_valid), 32'd1);
    chk("t3_w0_stable", 32'(a_rd_data), 32'h11);
    a_rd_ready = 1'b1;
    @(negedge clk);
    a_rd_ready = 1'b0;
    a_take(8'h22, "t3_w1");
    a_take(8'h33, "t3_w2");
    chk("t3_done", 32'(a_done), 32'd1);
    chk("t3_err", 32'(a_err), 32'd0);
    @(negedge clk);

    // 4: timeout, host never acks
    b_mute = 1'b1;
    b_issue(1'b0, 16'h9999, 4'd3);
    n = 0;
    while (!b_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_req_up", 32'(b_req), 32'd1);
    n = 0;
    while (b_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_req_cycles", 32'(n), 32'd16);
    chk("t4_done", 32'(b_done), 32'd1);
    chk("t4_err", 32'(b_err), 32'd1);
    chk("t4_oe", 32'(b_oe), 32'd0);
    chk("t4_bus_rd_off", 32'(b_rd), 32'd0);
    chk("t4_rd_valid", 32'(b_rd_valid), 32'd0);
    @(negedge clk);
    chk("t4_idle", 32'(b_cmd_ready), 32'd1);
    chk("t4_done_pulse", 32'(b_done), 32'd0);
    b_mute = 1'b0;

    // 5: ack already high at accept
    a_log.delete();
    a_rq.delete();
    a_rq.push_back(8'h5A);
    a_hold = 1'b1;
    repeat (4) @(negedge clk);
    a_issue(1'b0, 16'h00AB, 4'd0);
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (a_req) flag = 1'b1;
    end
    chk("t5_no_req_while_ack", 32'(flag), 32'd0);
    a_hold = 1'b0;
    @(negedge clk);
    chk("t5_ack_low", 32'(a_ack), 32'd0);
    n = 0;
    while (!a_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_req_latency", 32'(n), 32'd3);
    a_take(8'h5A, "t5_rd_data");
    chk("t5_done", 32'(a_done), 32'd1);
    chk("t5_err", 32'(a_err), 32'd0);
    a_chk_log(16'hFFAB, 16'hFF00, 16'h0000, "t5");
    @(negedge clk);

    // 6: reset during a read data beat
    a_log.delete();
    a_rq.delete();
    a_rq.push_back(8'h77);
    a_mute = 1'b1;
    a_issue(1'b0, 16'h0F0E, 4'd0);
    n = 0;
    while (!(a_req && a_oe == 8'h00) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_data_beat", 32'(a_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req", 32'(a_req), 32'd0);
    chk("t6_bus_rd", 32'(a_rd), 32'd0);
    chk("t6_cmd_ready", 32'(a_cmd_ready), 32'd1);
    chk("t6_busy", 32'(a_busy), 32'd0);
    chk("t6_oe", 32'(a_oe), 32'd0);
    chk("t6_dout", 32'(a_dout), 32'd0);
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_done) flag = 1'b1;
    end
    rst_n  = 1'b1;
    a_mute = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_done) flag = 1'b1;
    end
    chk("t6_no_done", 32'(flag), 32'd0);
    a_log.delete();
    a_rq.delete();
    a_rq.push_back(8'hC3);
    a_issue(1'b0, 16'h4321, 4'd0);
    a_take(8'hC3, "t6_rd_data");
    chk("t6_done", 32'(a_done), 32'd1);
    chk("t6_err", 32'(a_err), 32'd0);
    a_chk_log(16'hFF21, 16'hFF43, 16'h0000, "t6");
    @(negedge clk);
    chk("t6_idle", 32'(a_cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
